// File: rtl/crossbar_pkg.sv
// ============================================================================
// Module   : crossbar_pkg
// Brief    : Shared owner/state encodings for the 2x2 crossbar arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package crossbar_pkg;

    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_M1   = 2'd1,
        OWNER_M2   = 2'd2
    } owner_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } slot_state_t;

    function automatic int sel_bit(input int aw);
        return aw - 1;
    endfunction

    localparam int PKG_ADDR_W = 32;
    localparam int SEL_BIT    = sel_bit(PKG_ADDR_W);

endpackage

`default_nettype wire

// File: rtl/crossbar_arb_slot.sv
// ============================================================================
// Module   : crossbar_arb_slot
// Brief    : One slave's ownership FSM with round-robin priority pointer and
//            optional watchdog (CROSSBAR_ARB_TIMEOUT_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module crossbar_arb_slot
    import crossbar_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   i_cand_m1,
    input  logic   i_cand_m2,
    input  logic   i_ack,
`ifdef CROSSBAR_ARB_TIMEOUT_EN
    output logic   o_timeout,
`endif
    output owner_t o_owner
);

    slot_state_t r_state;
    owner_t      r_owner;
    owner_t      r_prio;

`ifdef CROSSBAR_ARB_TIMEOUT_EN
    localparam int               c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(TIMEOUT_CYCLES);

    logic [c_CNT_W-1:0] r_cnt;
    logic               r_timeout;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_owner   <= OWNER_NONE;
            r_prio    <= OWNER_M1;
`ifdef CROSSBAR_ARB_TIMEOUT_EN
            r_cnt     <= '0;
            r_timeout <= 1'b0;
`endif
        end else begin
`ifdef CROSSBAR_ARB_TIMEOUT_EN
            r_timeout <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (i_cand_m1 || i_cand_m2) begin
                        r_state <= BUSY;
                        if (i_cand_m1 && i_cand_m2)
                            r_owner <= r_prio;
                        else if (i_cand_m1)
                            r_owner <= OWNER_M1;
                        else
                            r_owner <= OWNER_M2;
`ifdef CROSSBAR_ARB_TIMEOUT_EN
                        r_cnt <= '0;
`endif
                    end
                end
                BUSY: begin
                    // Priority moves to the non-owner whether or not it is waiting.
                    if (i_ack) begin
                        r_state <= IDLE;
                        r_owner <= OWNER_NONE;
                        r_prio  <= (r_owner == OWNER_M1) ? OWNER_M2 : OWNER_M1;
                    end
`ifdef CROSSBAR_ARB_TIMEOUT_EN
                    else if (r_cnt == c_LIMIT) begin
                        r_state   <= IDLE;
                        r_owner   <= OWNER_NONE;
                        r_prio    <= (r_owner == OWNER_M1) ? OWNER_M2 : OWNER_M1;
                        r_timeout <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`endif
                end
                default: begin
                    r_state <= IDLE;
                    r_owner <= OWNER_NONE;
                end
            endcase
        end
    end

    assign o_owner = r_owner;
`ifdef CROSSBAR_ARB_TIMEOUT_EN
    assign o_timeout = r_timeout;
`endif

endmodule

`default_nettype wire

// File: rtl/crossbar_arbiter.sv
// ============================================================================
// Module   : crossbar_arbiter
// Brief    : 2-master x 2-slave registered round-robin arbiter/router.
//            Optional watchdog release enabled by CROSSBAR_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module crossbar_arbiter
    import crossbar_pkg::*;
#(
    parameter int ADDR_W         = PKG_ADDR_W,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              master_1_req,
    input  logic              master_1_cmd,
    input  logic [ADDR_W-1:0] master_1_addr,
    input  logic [DATA_W-1:0] master_1_wdata,
    output logic              master_1_ack,
    output logic [DATA_W-1:0] master_1_rdata,
    input  logic              master_2_req,
    input  logic              master_2_cmd,
    input  logic [ADDR_W-1:0] master_2_addr,
    input  logic [DATA_W-1:0] master_2_wdata,
    output logic              master_2_ack,
    output logic [DATA_W-1:0] master_2_rdata,
    output logic              slave_1_req,
    output logic              slave_1_cmd,
    output logic [ADDR_W-1:0] slave_1_addr,
    output logic [DATA_W-1:0] slave_1_wdata,
    input  logic              slave_1_ack,
    input  logic [DATA_W-1:0] slave_1_rdata,
    output logic              slave_2_req,
    output logic              slave_2_cmd,
    output logic [ADDR_W-1:0] slave_2_addr,
    output logic [DATA_W-1:0] slave_2_wdata,
    input  logic              slave_2_ack,
    input  logic [DATA_W-1:0] slave_2_rdata
`ifdef CROSSBAR_ARB_TIMEOUT_EN
    ,
    output logic              slave_1_timeout,
    output logic              slave_2_timeout
`endif
);

    localparam int c_SEL = sel_bit(ADDR_W);

    owner_t w_owner_1;
    owner_t w_owner_2;

    // Address MSB picks the slave: 0 -> slave_1, 1 -> slave_2.
    wire w_m1_to_s1 = master_1_req & ~master_1_addr[c_SEL];
    wire w_m1_to_s2 = master_1_req &  master_1_addr[c_SEL];
    wire w_m2_to_s1 = master_2_req & ~master_2_addr[c_SEL];
    wire w_m2_to_s2 = master_2_req &  master_2_addr[c_SEL];

    crossbar_arb_slot #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_slot_1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_cand_m1 (w_m1_to_s1),
        .i_cand_m2 (w_m2_to_s1),
        .i_ack     (slave_1_ack),
`ifdef CROSSBAR_ARB_TIMEOUT_EN
        .o_timeout (slave_1_timeout),
`endif
        .o_owner   (w_owner_1)
    );

    crossbar_arb_slot #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_slot_2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_cand_m1 (w_m1_to_s2),
        .i_cand_m2 (w_m2_to_s2),
        .i_ack     (slave_2_ack),
`ifdef CROSSBAR_ARB_TIMEOUT_EN
        .o_timeout (slave_2_timeout),
`endif
        .o_owner   (w_owner_2)
    );

    always_comb begin
        {slave_1_req, slave_1_cmd, slave_1_addr, slave_1_wdata} = '0;
        case (w_owner_1)
            OWNER_M1: {slave_1_req, slave_1_cmd, slave_1_addr, slave_1_wdata} =
                      {master_1_req, master_1_cmd, master_1_addr, master_1_wdata};
            OWNER_M2: {slave_1_req, slave_1_cmd, slave_1_addr, slave_1_wdata} =
                      {master_2_req, master_2_cmd, master_2_addr, master_2_wdata};
            default: ;
        endcase
    end

    always_comb begin
        {slave_2_req, slave_2_cmd, slave_2_addr, slave_2_wdata} = '0;
        case (w_owner_2)
            OWNER_M1: {slave_2_req, slave_2_cmd, slave_2_addr, slave_2_wdata} =
                      {master_1_req, master_1_cmd, master_1_addr, master_1_wdata};
            OWNER_M2: {slave_2_req, slave_2_cmd, slave_2_addr, slave_2_wdata} =
                      {master_2_req, master_2_cmd, master_2_addr, master_2_wdata};
            default: ;
        endcase
    end

    wire w_m1_owns_s1 = (w_owner_1 == OWNER_M1);
    wire w_m1_owns_s2 = (w_owner_2 == OWNER_M1);
    wire w_m2_owns_s1 = (w_owner_1 == OWNER_M2);
    wire w_m2_owns_s2 = (w_owner_2 == OWNER_M2);

    assign master_1_ack   = (w_m1_owns_s1 & slave_1_ack) | (w_m1_owns_s2 & slave_2_ack);
    assign master_2_ack   = (w_m2_owns_s1 & slave_1_ack) | (w_m2_owns_s2 & slave_2_ack);
    assign master_1_rdata = ({DATA_W{w_m1_owns_s1}} & slave_1_rdata)
                          | ({DATA_W{w_m1_owns_s2}} & slave_2_rdata);
    assign master_2_rdata = ({DATA_W{w_m2_owns_s1}} & slave_1_rdata)
                          | ({DATA_W{w_m2_owns_s2}} & slave_2_rdata);

endmodule

`default_nettype wire

// File: tb/tb_crossbar_arbiter.sv
// ============================================================================
// Module   : tb_crossbar_arbiter
// Brief    : Directed scoreboard bench for crossbar_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_crossbar_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    typedef struct packed {
        logic          cmd;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } gnt_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          master_1_req = 1'b0, master_1_cmd = 1'b0;
    logic [AW-1:0] master_1_addr = '0;
    logic [DW-1:0] master_1_wdata = '0;
    logic          master_1_ack;
    logic [DW-1:0] master_1_rdata;
    logic          master_2_req = 1'b0, master_2_cmd = 1'b0;
    logic [AW-1:0] master_2_addr = '0;
    logic [DW-1:0] master_2_wdata = '0;
    logic          master_2_ack;
    logic [DW-1:0] master_2_rdata;
    logic          slave_1_req, slave_1_cmd;
    logic [AW-1:0] slave_1_addr;
    logic [DW-1:0] slave_1_wdata;
    logic          slave_1_ack = 1'b0;
    logic [DW-1:0] slave_1_rdata = '0;
    logic          slave_2_req, slave_2_cmd;
    logic [AW-1:0] slave_2_addr;
    logic [DW-1:0] slave_2_wdata;
    logic          slave_2_ack = 1'b0;
    logic [DW-1:0] slave_2_rdata = '0;
`ifdef CROSSBAR_ARB_TIMEOUT_EN
    logic          slave_1_timeout, slave_2_timeout;
`endif

    int n_checks = 0;
    int n_errors = 0;

    gnt_t          g1_q[$], g2_q[$];
    logic [DW-1:0] a1_q[$], a2_q[$];

    always #5 clk = ~clk;

    crossbar_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .master_1_req(master_1_req), .master_1_cmd(master_1_cmd),
        .master_1_addr(master_1_addr), .master_1_wdata(master_1_wdata),
        .master_1_ack(master_1_ack), .master_1_rdata(master_1_rdata),
        .master_2_req(master_2_req), .master_2_cmd(master_2_cmd),
        .master_2_addr(master_2_addr), .master_2_wdata(master_2_wdata),
        .master_2_ack(master_2_ack), .master_2_rdata(master_2_rdata),
        .slave_1_req(slave_1_req), .slave_1_cmd(slave_1_cmd),
        .slave_1_addr(slave_1_addr), .slave_1_wdata(slave_1_wdata),
        .slave_1_ack(slave_1_ack), .slave_1_rdata(slave_1_rdata),
        .slave_2_req(slave_2_req), .slave_2_cmd(slave_2_cmd),
        .slave_2_addr(slave_2_addr), .slave_2_wdata(slave_2_wdata),
        .slave_2_ack(slave_2_ack), .slave_2_rdata(slave_2_rdata)
`ifdef CROSSBAR_ARB_TIMEOUT_EN
        , .slave_1_timeout(slave_1_timeout), .slave_2_timeout(slave_2_timeout)
`endif
    );

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic gnt_t mk(input logic c, input logic [AW-1:0] a, input logic [DW-1:0] d);
        gnt_t g;
        g.cmd = c; g.addr = a; g.wdata = d;
        return g;
    endfunction

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic drv_m1(input logic r, input logic c, input logic [AW-1:0] a, input logic [DW-1:0] d);
        master_1_req = r; master_1_cmd = c; master_1_addr = a; master_1_wdata = d;
    endtask

    task automatic drv_m2(input logic r, input logic c, input logic [AW-1:0] a, input logic [DW-1:0] d);
        master_2_req = r; master_2_cmd = c; master_2_addr = a; master_2_wdata = d;
    endtask

    // Pulse a slave ack this cycle and record which master must receive it.
    task automatic ack_s(input int s, input logic [DW-1:0] d, input int m);
        if (s == 1) begin slave_1_ack = 1'b1; slave_1_rdata = d; end
        else        begin slave_2_ack = 1'b1; slave_2_rdata = d; end
        if (m == 1) a1_q.push_back(d); else a2_q.push_back(d);
    endtask

    task automatic clr_ack();
        slave_1_ack = 1'b0; slave_1_rdata = '0;
        slave_2_ack = 1'b0; slave_2_rdata = '0;
    endtask

    // Monitor: a new grant (slave req rising) or a master ack pops the scoreboard.
    initial begin
        logic p1, p2;
        gnt_t g;
        logic [DW-1:0] d;
        p1 = 1'b0; p2 = 1'b0;
        forever begin
            @(negedge clk);
            if (slave_1_req === 1'b1 && p1 !== 1'b1) begin
                if (g1_q.size() == 0) chk("grant_s1_unexpected", 96'(slave_1_wdata), 96'hDEAD);
                else begin
                    g = g1_q.pop_front();
                    chk("grant_s1", 96'({slave_1_cmd, slave_1_addr, slave_1_wdata}), 96'(g));
                end
            end
            if (slave_2_req === 1'b1 && p2 !== 1'b1) begin
                if (g2_q.size() == 0) chk("grant_s2_unexpected", 96'(slave_2_wdata), 96'hDEAD);
                else begin
                    g = g2_q.pop_front();
                    chk("grant_s2", 96'({slave_2_cmd, slave_2_addr, slave_2_wdata}), 96'(g));
                end
            end
            if (master_1_ack === 1'b1) begin
                if (a1_q.size() == 0) chk("ack_m1_unexpected", 96'(master_1_rdata), 96'hDEAD);
                else begin
                    d = a1_q.pop_front();
                    chk("ack_m1_rdata", 96'(master_1_rdata), 96'(d));
                end
            end
            if (master_2_ack === 1'b1) begin
                if (a2_q.size() == 0) chk("ack_m2_unexpected", 96'(master_2_rdata), 96'hDEAD);
                else begin
                    d = a2_q.pop_front();
                    chk("ack_m2_rdata", 96'(master_2_rdata), 96'(d));
                end
            end
            p1 = slave_1_req;
            p2 = slave_2_req;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_slave_req", 96'({slave_1_req, slave_2_req}), 96'(0));
        chk("rst_slave_bus", 96'({slave_1_addr, slave_2_wdata}), 96'(0));
        chk("rst_master_ack", 96'({master_1_ack, master_2_ack}), 96'(0));
        chk("rst_master_rdata", 96'({master_1_rdata, master_2_rdata}), 96'(0));
        cyc(); rst_n = 1'b1;

        // Single write M1 -> slave_1
        drv_m1(1, 1, 32'h0000_0010, 32'hA5A5_A5A5);
        g1_q.push_back(mk(1, 32'h0000_0010, 32'hA5A5_A5A5));
        @(negedge clk); chk("t1_no_comb_grant", 96'(slave_1_req), 96'(0));
        cyc(); cyc(); cyc();
        ack_s(1, 32'h1234_5678, 1);
        @(negedge clk); chk("t1_ack_zero_latency", 96'(master_1_ack), 96'(1));
        cyc(); clr_ack(); drv_m1(0, 0, '0, '0);
        @(negedge clk);
        chk("t1_idle_outputs", 96'({slave_1_req, slave_1_cmd, slave_1_addr, slave_1_wdata}), 96'(0));
        cyc();

        // Conflict on slave_2, round-robin with re-request during bubble
        drv_m1(1, 0, 32'h8000_0000, 32'h1);
        drv_m2(1, 1, 32'h8000_0000, 32'h2);
        g2_q.push_back(mk(0, 32'h8000_0000, 32'h1));
        g2_q.push_back(mk(1, 32'h8000_0000, 32'h2));
        g2_q.push_back(mk(0, 32'h8000_0000, 32'h3));
        cyc();
        ack_s(2, 32'hAAAA_0001, 1);
        @(negedge clk); chk("t2_first_owner", 96'(slave_2_wdata), 96'h1);
        cyc(); clr_ack(); drv_m1(1, 0, 32'h8000_0000, 32'h3);
        @(negedge clk); chk("t2_bubble", 96'(slave_2_req), 96'(0));
        cyc();
        ack_s(2, 32'hBBBB_0002, 2);
        @(negedge clk); chk("t2_rr_owner_m2", 96'(slave_2_wdata), 96'h2);
        cyc(); clr_ack(); drv_m2(0, 0, '0, '0);
        @(negedge clk); chk("t2_bubble2", 96'(slave_2_req), 96'(0));
        cyc();
        ack_s(2, 32'hCCCC_0003, 1);
        @(negedge clk); chk("t2_rr_owner_m1", 96'(slave_2_wdata), 96'h3);
        cyc(); clr_ack(); drv_m1(0, 0, '0, '0);
        cyc();

        // Parallel independent slots
        drv_m1(1, 1, 32'h0000_0004, 32'h44);
        drv_m2(1, 0, 32'h8000_0004, 32'h88);
        g1_q.push_back(mk(1, 32'h0000_0004, 32'h44));
        g2_q.push_back(mk(0, 32'h8000_0004, 32'h88));
        cyc();
        @(negedge clk); chk("t3_both_busy", 96'({slave_1_req, slave_2_req}), 96'(3));
        cyc();
        ack_s(1, 32'h0000_5111, 1);
        @(negedge clk); chk("t3_m2_isolated", 96'({master_2_ack, master_2_rdata}), 96'(0));
        cyc(); clr_ack(); drv_m1(0, 0, '0, '0);
        slave_1_rdata = 32'hDEAD_BEEF;
        ack_s(2, 32'h0000_6222, 2);
        @(negedge clk); chk("t3_m1_owns_nothing", 96'({master_1_ack, master_1_rdata}), 96'(0));
        cyc(); clr_ack(); drv_m2(0, 0, '0, '0);
        cyc();

        // Stray ack on idle slave_2, then conflict must still start with M1
        slave_2_ack = 1'b1; slave_2_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("t4_stray_ack", 96'({master_1_ack, master_2_ack}), 96'(0));
        chk("t4_stray_rdata", 96'(master_2_rdata), 96'(0));
        cyc(); clr_ack();
        drv_m1(1, 0, 32'h8000_0040, 32'h41);
        drv_m2(1, 0, 32'h8000_0080, 32'h42);
        g2_q.push_back(mk(0, 32'h8000_0040, 32'h41));
        g2_q.push_back(mk(0, 32'h8000_0080, 32'h42));
        cyc(); ack_s(2, 32'h4141, 1);
        cyc(); clr_ack(); drv_m1(0, 0, '0, '0);
        cyc(); ack_s(2, 32'h4242, 2);
        cyc(); clr_ack(); drv_m2(0, 0, '0, '0);
        cyc();

        // Reset in the middle of a BUSY slot
        drv_m1(1, 0, 32'h0000_0020, 32'h77);
        g1_q.push_back(mk(0, 32'h0000_0020, 32'h77));
        cyc(); cyc(); rst_n = 1'b0;
        cyc(); rst_n = 1'b1; drv_m1(0, 0, '0, '0);
        @(negedge clk);
        chk("t5_rst_outputs", 96'({slave_1_req, slave_1_addr, slave_1_wdata}), 96'(0));
        cyc(); slave_1_ack = 1'b1; slave_1_rdata = 32'h99;
        @(negedge clk); chk("t5_late_ack", 96'({master_1_ack, master_1_rdata}), 96'(0));
        cyc(); clr_ack();
        cyc();

`ifdef CROSSBAR_ARB_TIMEOUT_EN
        // Watchdog release with TIMEOUT_CYCLES=4; M2 waits behind M1
        drv_m1(1, 0, 32'h0000_0030, 32'h61);
        drv_m2(1, 0, 32'h0000_0040, 32'h62);
        g1_q.push_back(mk(0, 32'h0000_0030, 32'h61));
        g1_q.push_back(mk(0, 32'h0000_0040, 32'h62));
        for (int k = 1; k <= 7; k++) begin
            cyc();
            if (k == 6) drv_m1(0, 0, '0, '0);
            if (k == 7) ack_s(1, 32'h7777, 2);
            @(negedge clk);
            chk($sformatf("t6_timeout_c%0d", k), 96'({slave_1_timeout, slave_2_timeout}),
                96'({(k == 6), 1'b0}));
        end
        cyc(); clr_ack(); drv_m2(0, 0, '0, '0);
        cyc();
`endif

        repeat (3) cyc();
        chk("sb_drain_grants", 96'(g1_q.size() + g2_q.size()), 96'(0));
        chk("sb_drain_acks", 96'(a1_q.size() + a2_q.size()), 96'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
